// File: rtl/irq_pkg.sv
// Shared constants for the interrupt priority controller: register map,
// id width and default sizing.
package irq_pkg;

    localparam int IRQ_ID_W    = 5;
    localparam int DEF_NUM_SRC = 8;
    localparam int DEF_PRIO_W  = 3;
    localparam int CFG_AW      = 6;
    localparam int CFG_DW      = 32;

    localparam logic [CFG_AW-1:0] ADDR_ENABLE    = 6'h00;
    localparam logic [CFG_AW-1:0] ADDR_MODE      = 6'h01;
    localparam logic [CFG_AW-1:0] ADDR_THRESHOLD = 6'h02;
    localparam logic [CFG_AW-1:0] ADDR_PENDING   = 6'h03;
    localparam logic [CFG_AW-1:0] ADDR_INSVC     = 6'h04;
    localparam logic [CFG_AW-1:0] ADDR_PRIO_BASE = 6'h08;

endpackage

// File: rtl/irq_prio_ctrl_if.sv
// Configuration register bus of the interrupt controller.
interface irq_prio_ctrl_if;
    import irq_pkg::*;

    logic              i_cfg_wren;
    logic              i_cfg_rden;
    logic [CFG_AW-1:0] i_cfg_addr;
    logic [CFG_DW-1:0] i_cfg_wdata;
    logic [CFG_DW-1:0] o_cfg_rdata;
    logic              o_cfg_rvalid;

    modport master (
        output i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_wdata,
        input  o_cfg_rdata, o_cfg_rvalid
    );

    modport slave (
        input  i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_wdata,
        output o_cfg_rdata, o_cfg_rvalid
    );
endinterface

// File: rtl/irq_prio_arb.sv
// Combinational arbiter: picks the eligible source with the highest
// priority; among equal priorities the lowest index wins.
module irq_prio_arb
    import irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int PRIO_W  = DEF_PRIO_W
) (
    input  logic [NUM_SRC-1:0]             i_elig,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] i_prio,
    output logic                           o_valid,
    output logic [IRQ_ID_W-1:0]            o_id
);
    logic [PRIO_W-1:0] best;

    // Scan high index to low with >= so a lower index overrides on a tie.
    always_comb begin
        best    = '0;
        o_id    = '0;
        o_valid = |i_elig;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_elig[k] && (i_prio[k] >= best)) begin
                best = i_prio[k];
                o_id = IRQ_ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt priority controller: per-source edge/level capture, claim and
// complete tracking, threshold masking and a registered winner selection.
module irq_prio_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int PRIO_W  = DEF_PRIO_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_SRC-1:0]  i_irq,
    output logic [31:0]         o_irq,
    output logic                o_irq_valid,
    output logic [IRQ_ID_W-1:0] o_irq_id,
    input  logic                i_irq_ack,
    input  logic [IRQ_ID_W-1:0] i_irq_id,
    input  logic                i_irq_cmpl,
    input  logic [IRQ_ID_W-1:0] i_cmpl_id,
    irq_prio_ctrl_if.slave      cfg
);
    logic [NUM_SRC-1:0]             enable_q, enable_d, mode_q, mode_d;
    logic [NUM_SRC-1:0]             pend_q, pend_d, insvc_q, insvc_d;
    logic [NUM_SRC-1:0]             pre_q, irq_q, irq_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [PRIO_W-1:0]              thresh_q, thresh_d;
    logic                           arm_q;
    logic                           valid_q;
    logic [IRQ_ID_W-1:0]            id_q;
    logic [CFG_DW-1:0]              rdata_q, rdata_d;
    logic                           rvalid_q;

    logic [NUM_SRC-1:0] claim_oh, cmpl_oh, edge_set, lvl_set, elig;
    logic               arb_valid;
    logic [IRQ_ID_W-1:0] arb_id;

    // Pending / in-service next state. A fresh edge beats a same-cycle claim;
    // level re-pending waits until the source leaves service. arm_q blocks
    // the first cycle after reset so a line held high is not seen as an edge.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            claim_oh[k] = i_irq_ack  && (i_irq_id  == IRQ_ID_W'(k));
            cmpl_oh[k]  = i_irq_cmpl && (i_cmpl_id == IRQ_ID_W'(k));
            elig[k]     = pend_q[k] && enable_q[k] && !insvc_q[k] &&
                          (prio_q[k] > thresh_q);
        end
        edge_set = mode_q & i_irq & ~pre_q & {NUM_SRC{arm_q}};
        lvl_set  = ~mode_q & i_irq & ~insvc_q & ~claim_oh;
        pend_d   = (pend_q & ~claim_oh) | edge_set | lvl_set;
        insvc_d  = (insvc_q & ~cmpl_oh) | claim_oh;
        irq_d    = pend_q & enable_q;
    end

    irq_prio_arb #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) u_arb (
        .i_elig  (elig),
        .i_prio  (prio_q),
        .o_valid (arb_valid),
        .o_id    (arb_id)
    );

    // Register writes and read mux; reads always see pre-write values.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        rdata_d  = '0;
        if (cfg.i_cfg_wren) begin
            case (cfg.i_cfg_addr)
                ADDR_ENABLE:    enable_d = cfg.i_cfg_wdata[NUM_SRC-1:0];
                ADDR_MODE:      mode_d   = cfg.i_cfg_wdata[NUM_SRC-1:0];
                ADDR_THRESHOLD: thresh_d = cfg.i_cfg_wdata[PRIO_W-1:0];
                default: ;
            endcase
            for (int k = 0; k < NUM_SRC; k++)
                if (cfg.i_cfg_addr == ADDR_PRIO_BASE + CFG_AW'(k))
                    prio_d[k] = cfg.i_cfg_wdata[PRIO_W-1:0];
        end
        if (cfg.i_cfg_rden) begin
            case (cfg.i_cfg_addr)
                ADDR_ENABLE:    rdata_d = CFG_DW'(enable_q);
                ADDR_MODE:      rdata_d = CFG_DW'(mode_q);
                ADDR_THRESHOLD: rdata_d = CFG_DW'(thresh_q);
                ADDR_PENDING:   rdata_d = CFG_DW'(pend_q);
                ADDR_INSVC:     rdata_d = CFG_DW'(insvc_q);
                default: ;
            endcase
            for (int k = 0; k < NUM_SRC; k++)
                if (cfg.i_cfg_addr == ADDR_PRIO_BASE + CFG_AW'(k))
                    rdata_d = CFG_DW'(prio_q[k]);
        end
    end

    // All state, single clock domain with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable_q <= '0;
            mode_q   <= '0;
            thresh_q <= '0;
            for (int k = 0; k < NUM_SRC; k++) prio_q[k] <= PRIO_W'(1);
            pend_q   <= '0;
            insvc_q  <= '0;
            pre_q    <= '0;
            arm_q    <= 1'b0;
            irq_q    <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            thresh_q <= thresh_d;
            prio_q   <= prio_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            pre_q    <= i_irq;
            arm_q    <= 1'b1;
            irq_q    <= irq_d;
            valid_q  <= arb_valid;
            id_q     <= arb_id;
            rdata_q  <= rdata_d;
            rvalid_q <= cfg.i_cfg_rden;
        end
    end

    assign o_irq            = 32'(irq_q);
    assign o_irq_valid      = valid_q;
    assign o_irq_id         = id_q;
    assign cfg.o_cfg_rdata  = rdata_q;
    assign cfg.o_cfg_rvalid = rvalid_q;
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl (NUM_SRC=8, PRIO_W=3).
module tb_irq_prio_ctrl;
    import irq_pkg::*;

    logic                i_clk;
    logic                i_rst_n;
    logic [7:0]          i_irq;
    logic [31:0]         o_irq;
    logic                o_irq_valid;
    logic [IRQ_ID_W-1:0] o_irq_id;
    logic                i_irq_ack, i_irq_cmpl;
    logic [IRQ_ID_W-1:0] i_irq_id, i_cmpl_id;
    int                  checks = 0;
    int                  errors = 0;

    irq_prio_ctrl_if bus ();

    irq_prio_ctrl #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_irq       (i_irq),
        .o_irq       (o_irq),
        .o_irq_valid (o_irq_valid),
        .o_irq_id    (o_irq_id),
        .i_irq_ack   (i_irq_ack),
        .i_irq_id    (i_irq_id),
        .i_irq_cmpl  (i_irq_cmpl),
        .i_cmpl_id   (i_cmpl_id),
        .cfg         (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [5:0] a, input logic [31:0] d);
        bus.i_cfg_wren  = 1'b1;
        bus.i_cfg_addr  = a;
        bus.i_cfg_wdata = d;
        tick();
        bus.i_cfg_wren  = 1'b0;
    endtask

    task automatic cfg_rd(input logic [5:0] a, input string tag, input logic [31:0] exp);
        bus.i_cfg_rden = 1'b1;
        bus.i_cfg_addr = a;
        tick();
        bus.i_cfg_rden = 1'b0;
        chk({tag, "_rvalid"}, 32'(bus.o_cfg_rvalid), 32'd1);
        chk(tag, bus.o_cfg_rdata, exp);
    endtask

    task automatic claim(input logic [4:0] id);
        i_irq_ack = 1'b1; i_irq_id = id; tick(); i_irq_ack = 1'b0;
    endtask

    task automatic cmpl(input logic [4:0] id);
        i_irq_cmpl = 1'b1; i_cmpl_id = id; tick(); i_irq_cmpl = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_irq = '0; i_irq_ack = 0; i_irq_id = '0; i_irq_cmpl = 0; i_cmpl_id = '0;
        bus.i_cfg_wren = 0; bus.i_cfg_rden = 0; bus.i_cfg_addr = '0; bus.i_cfg_wdata = '0;
        tick(); tick();
        chk("rst_o_irq", o_irq, 32'h0);
        chk("rst_valid", 32'(o_irq_valid), 32'h0);
        chk("rst_id", 32'(o_irq_id), 32'h0);
        chk("rst_rvalid", 32'(bus.o_cfg_rvalid), 32'h0);
        i_rst_n = 1'b1;
        tick();
        cfg_rd(6'h08, "rst_prio0", 32'h1);
        chk("rvalid_one_cycle", 32'(bus.o_cfg_rvalid), 32'h1);
        tick();
        chk("rvalid_drops", 32'(bus.o_cfg_rvalid), 32'h0);
        cfg_rd(6'h02, "rst_thresh", 32'h0);

        // two edge sources, different priorities
        cfg_wr(6'h00, 32'h3); cfg_wr(6'h01, 32'h3);
        cfg_wr(6'h08, 32'h2); cfg_wr(6'h09, 32'h5);
        i_irq = 8'h03; tick(); i_irq = 8'h00;
        chk("arb_latency", 32'(o_irq_valid), 32'h0);
        tick();
        chk("arb_valid", 32'(o_irq_valid), 32'h1);
        chk("arb_id1", 32'(o_irq_id), 32'h1);
        chk("arb_o_irq", o_irq, 32'h3);

        // claim 1 -> source 0 offered; complete 1 without new edge
        claim(5'd1); tick();
        chk("claim_id0", 32'(o_irq_id), 32'h0);
        chk("claim_o_irq", o_irq, 32'h1);
        cmpl(5'd1); tick();
        chk("cmpl_no_reassert", 32'(o_irq_id), 32'h0);
        cfg_rd(6'h04, "insvc_clear", 32'h0);
        i_irq = 8'h02; tick(); i_irq = 8'h00; tick();
        chk("new_edge_id1", 32'(o_irq_id), 32'h1);
        claim(5'd1); claim(5'd0); cmpl(5'd1); cmpl(5'd0); tick(); tick();
        chk("drained_valid", 32'(o_irq_valid), 32'h0);
        chk("drained_o_irq", o_irq, 32'h0);

        // claim and complete same id same cycle; out-of-range claim
        i_irq_ack = 1; i_irq_id = 5'd4; i_irq_cmpl = 1; i_cmpl_id = 5'd4;
        tick();
        i_irq_ack = 0; i_irq_cmpl = 0;
        cfg_rd(6'h04, "claim_wins", 32'h10);
        cmpl(5'd4);
        claim(5'd8);
        cfg_rd(6'h04, "claim_oor", 32'h0);

        // level source 2 held high
        cfg_wr(6'h0A, 32'h3); cfg_wr(6'h00, 32'h7);
        i_irq = 8'h04; tick(); tick();
        chk("lvl_valid", 32'(o_irq_valid), 32'h1);
        chk("lvl_id", 32'(o_irq_id), 32'h2);
        claim(5'd2); tick(); tick();
        chk("lvl_insvc_hidden", 32'(o_irq_valid), 32'h0);
        cfg_rd(6'h03, "lvl_no_repend", 32'h0);
        cmpl(5'd2); tick(); tick();
        chk("lvl_reoffer_valid", 32'(o_irq_valid), 32'h1);
        chk("lvl_reoffer_id", 32'(o_irq_id), 32'h2);
        i_irq = 8'h00; claim(5'd2); cmpl(5'd2); tick(); tick();
        chk("lvl_drained", 32'(o_irq_valid), 32'h0);

        // threshold masking
        cfg_wr(6'h01, 32'hFF); cfg_wr(6'h0B, 32'h4);
        cfg_wr(6'h02, 32'h4); cfg_wr(6'h00, 32'h8);
        i_irq = 8'h08; tick(); i_irq = 8'h00; tick(); tick();
        chk("thr_masked_valid", 32'(o_irq_valid), 32'h0);
        chk("thr_masked_o_irq", o_irq, 32'h8);
        bus.i_cfg_wren = 1; bus.i_cfg_rden = 1; bus.i_cfg_addr = 6'h02; bus.i_cfg_wdata = 32'h3;
        tick();
        bus.i_cfg_wren = 0; bus.i_cfg_rden = 0;
        chk("wr_rd_old", bus.o_cfg_rdata, 32'h4);
        chk("thr_not_yet", 32'(o_irq_valid), 32'h0);
        tick();
        chk("thr_open_valid", 32'(o_irq_valid), 32'h1);
        chk("thr_open_id", 32'(o_irq_id), 32'h3);
        cfg_rd(6'h02, "thr_readback", 32'h3);
        cfg_wr(6'h05, 32'hFFFF);
        cfg_rd(6'h05, "unmapped", 32'h0);
        cfg_wr(6'h00, 32'hFFFF_FF28);
        cfg_rd(6'h00, "enable_upper", 32'h28);

        // equal priority tie; edge coinciding with claim
        cfg_wr(6'h02, 32'h0); cfg_wr(6'h0B, 32'h3); cfg_wr(6'h0D, 32'h3);
        i_irq = 8'h20; tick(); i_irq = 8'h00; tick(); tick();
        chk("tie_id", 32'(o_irq_id), 32'h3);
        chk("tie_o_irq", o_irq, 32'h28);
        i_irq = 8'h08; claim(5'd3); i_irq = 8'h00;
        cfg_rd(6'h03, "edge_claim_pend", 32'h28);
        chk("insvc_not_offered", 32'(o_irq_id), 32'h5);
        cfg_rd(6'h04, "insvc3", 32'h08);
        cfg_wr(6'h01, 32'hDF);
        cfg_rd(6'h03, "mode_keep_pend", 32'h28);
        chk("pre_rst_o_irq", o_irq, 32'h28);

        // asynchronous reset mid-read and mid-claim
        bus.i_cfg_rden = 1; bus.i_cfg_addr = 6'h03;
        i_irq_ack = 1; i_irq_id = 5'd5;
        #3 i_rst_n = 1'b0;
        #1;
        chk("async_o_irq", o_irq, 32'h0);
        chk("async_valid", 32'(o_irq_valid), 32'h0);
        chk("async_id", 32'(o_irq_id), 32'h0);
        chk("async_rdata", bus.o_cfg_rdata, 32'h0);
        chk("async_rvalid", 32'(bus.o_cfg_rvalid), 32'h0);
        tick(); tick();
        bus.i_cfg_rden = 0; i_irq_ack = 0; i_irq = 8'h01;
        i_rst_n = 1'b1;
        cfg_rd(6'h08, "post_rst_prio0", 32'h1);
        cfg_rd(6'h03, "post_rst_lvl_pend", 32'h1);
        cfg_rd(6'h04, "post_rst_insvc", 32'h0);
        chk("post_rst_valid", 32'(o_irq_valid), 32'h0);
        chk("post_rst_o_irq", o_irq, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
